// File: rtl/cordic_input_standardizer_pipe.sv
// Two-stage elastic pipe that folds a CORDIC input vector into quadrant 0 and reports the
// quadrant, the residual or offset angle, and whether a negation had to saturate.
module cordic_input_standardizer_pipe #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ANGLE_W = 16,
  parameter int unsigned TAG_W   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [DATA_W-1:0]  in_x,
  input  logic signed [DATA_W-1:0]  in_y,
  input  logic        [ANGLE_W-1:0] in_theta,
  input  logic                      in_mode,
  input  logic        [TAG_W-1:0]   in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [DATA_W-1:0]  out_x,
  output logic signed [DATA_W-1:0]  out_y,
  output logic        [ANGLE_W-1:0] out_theta,
  output logic        [1:0]         out_quadrant,
  output logic                      out_mode,
  output logic        [TAG_W-1:0]   out_tag,
  output logic                      out_sat
);

  localparam logic signed [DATA_W-1:0] MinVal = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] MaxVal = {1'b0, {(DATA_W-1){1'b1}}};

  function automatic logic signed [DATA_W-1:0] sat_neg(input logic signed [DATA_W-1:0] v);
    return (v == MinVal) ? MaxVal : -v;
  endfunction

  // Full-turn bit carries no information once the angle wraps.
  logic unused_theta_msb;
  assign unused_theta_msb = in_theta[ANGLE_W-1];

  logic                      s1_valid;
  logic signed [DATA_W-1:0]  s1_x, s1_y;
  logic        [ANGLE_W-1:0] s1_theta;
  logic        [1:0]         s1_q, s1_sel;
  logic                      s1_mode;
  logic        [TAG_W-1:0]   s1_tag;
  logic                      s2_valid;

  logic                      s2_adv;
  logic        [1:0]         in_q, in_sel;
  logic        [ANGLE_W-1:0] in_theta_std;
  logic signed [DATA_W-1:0]  rot_x, rot_y;
  logic                      rot_sat;

  assign s2_adv    = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s2_adv;
  assign out_valid = s2_valid;

  // Vectoring rotates the opposite way to rotation, so quadrants 1 and 3 swap their mapping.
  always_comb begin
    in_q         = in_theta[ANGLE_W-2 -: 2];
    in_sel       = in_q;
    in_theta_std = {3'b000, in_theta[ANGLE_W-4:0]};
    if (in_mode) begin
      in_q         = {in_y[DATA_W-1], in_x[DATA_W-1] ^ in_y[DATA_W-1]};
      in_sel       = {in_q[1] ^ in_q[0], in_q[0]};
      in_theta_std = {1'b0, in_q, {(ANGLE_W-3){1'b0}}};
    end
  end

  always_comb begin
    rot_x   = s1_x;
    rot_y   = s1_y;
    rot_sat = 1'b0;
    unique case (s1_sel)
      2'd0: begin
        rot_x = s1_x;
        rot_y = s1_y;
      end
      2'd1: begin
        rot_x   = sat_neg(s1_y);
        rot_y   = s1_x;
        rot_sat = (s1_y == MinVal);
      end
      2'd2: begin
        rot_x   = sat_neg(s1_x);
        rot_y   = sat_neg(s1_y);
        rot_sat = (s1_x == MinVal) || (s1_y == MinVal);
      end
      2'd3: begin
        rot_x   = s1_y;
        rot_y   = sat_neg(s1_x);
        rot_sat = (s1_x == MinVal);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid     <= 1'b0;
      s1_x         <= '0;
      s1_y         <= '0;
      s1_theta     <= '0;
      s1_q         <= '0;
      s1_sel       <= '0;
      s1_mode      <= 1'b0;
      s1_tag       <= '0;
      s2_valid     <= 1'b0;
      out_x        <= '0;
      out_y        <= '0;
      out_theta    <= '0;
      out_quadrant <= '0;
      out_mode     <= 1'b0;
      out_tag      <= '0;
      out_sat      <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_x     <= in_x;
          s1_y     <= in_y;
          s1_theta <= in_theta_std;
          s1_q     <= in_q;
          s1_sel   <= in_sel;
          s1_mode  <= in_mode;
          s1_tag   <= in_tag;
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_x        <= rot_x;
          out_y        <= rot_y;
          out_theta    <= s1_theta;
          out_quadrant <= s1_q;
          out_mode     <= s1_mode;
          out_tag      <= s1_tag;
          out_sat      <= rot_sat;
        end
      end
    end
  end

endmodule

// File: doc/cordic_input_standardizer_pipe.md
CORDIC_INPUT_STANDARDIZER_PIPE -- requirements
Module: cordic_input_standardizer_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 16: signed width of x/y, two's complement.
REQ-002 SHALL have parameter ANGLE_W, default 16: angle width.
  - Full turn = 2^(ANGLE_W-1); quarter turn Q = 2^(ANGLE_W-3).
REQ-003 SHALL have parameter TAG_W, default 4: width of the sideband tag carried unchanged.
REQ-004 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1: input beat present.
REQ-007 SHALL have port in_ready, output, 1: block accepts a beat this cycle.
REQ-008 SHALL have ports in_x and in_y, input, DATA_W, signed: vector components.
REQ-009 SHALL have port in_theta, input, ANGLE_W, unsigned: angle; MSB ignored (full turn wraps to 0).
REQ-010 SHALL have port in_mode, input, 1: 0 = rotation, 1 = vectoring.
REQ-011 SHALL have port in_tag, input, TAG_W: sideband data.
REQ-012 SHALL have port out_valid, output, 1: output beat present.
REQ-013 SHALL have port out_ready, input, 1: downstream accepts.
REQ-014 SHALL have ports out_x and out_y, output, DATA_W, signed: standardized vector.
REQ-015 SHALL have port out_theta, output, ANGLE_W: residual angle (rotation) or offset angle (vectoring).
REQ-016 SHALL have ports out_quadrant, output, 2, and out_mode, output, 1: quadrant and mode of the beat.
REQ-017 SHALL have ports out_tag, output, TAG_W, and out_sat, output, 1: tag and negation-saturation flag.

Function
REQ-018 SHALL transfer a beat on the input when in_valid && in_ready, and on the output when out_valid && out_ready.
REQ-019 SHALL be a 2-stage elastic pipeline.
  - S1 registers the inputs and decodes the quadrant.
  - S2 registers the rotated, saturated results.
  - A beat accepted in cycle N SHALL present out_valid in cycle N+2 when not stalled.
REQ-020 SHALL sustain 1 beat/cycle: in_ready = !s1_valid || !s2_valid || out_ready.
  - Stage advance conditions SHALL be consistent with this equation.
  - No bubble SHALL be inserted while out_ready stays high.
REQ-021 SHALL hold all out_* stable while out_valid && !out_ready, and SHALL never drop, duplicate or reorder beats.
REQ-022 Rotation mode:
  - q = in_theta[ANGLE_W-2:ANGLE_W-3]; out_theta = in_theta mod Q, upper bits zero.
  - q0 -> (x,y); q1 -> (-y,x); q2 -> (-x,-y); q3 -> (y,-x).
REQ-023 Vectoring mode (in_theta ignored):
  - q = 0 if x>=0,y>=0; q = 1 if x<0,y>=0; q = 2 if x<0,y<0; q = 3 if x>=0,y<0.
  - q0 -> (x,y); q1 -> (y,-x); q2 -> (-x,-y); q3 -> (-y,x).
  - out_theta = q*Q.
REQ-024 Negation of -2^(DATA_W-1) SHALL yield 2^(DATA_W-1)-1 and set out_sat for that beat; otherwise out_sat = 0.
REQ-025 out_quadrant = q; out_mode and out_tag SHALL equal the values accepted with the beat.
REQ-026 Arithmetic SHALL wrap nowhere: every rotated component is a negation or a pass-through only.
REQ-027 Simultaneous output pop and input push on a full pipe SHALL both occur in the same cycle.

Reset
REQ-028 While rst is high at a clock edge:
  - s1_valid and s2_valid SHALL clear, so out_valid = 0 the next cycle.
  - out_x, out_y, out_theta, out_quadrant, out_mode, out_tag and out_sat SHALL be 0.
REQ-029 Reset mid-stream SHALL discard all in-flight beats.
  - in_ready SHALL be 1 in the first cycle after rst deasserts.
  - Inputs presented during rst SHALL NOT be accepted.

Verification
REQ-030 Rotation: x=10000, y=5000, theta=8193, mode 0, out_ready=1 -> 2 cycles later out=(-5000,10000), theta=1, q=1, sat=0.
REQ-031 Wrap: x=20000, y=1000, theta=32768 -> out=(20000,1000), theta=0, q=0.
  - Second beat with theta=32767 -> q=3, theta=8191, out=(1000,-20000).
REQ-032 Saturation: x=-32768, y=0, theta=16384 -> out=(32767,0), q=2, sat=1.
REQ-033 Vectoring: x=-8000, y=4000, mode 1 -> out=(4000,8000), q=1, theta=8192.
  - Second beat x=0, y=-5 -> out=(5,0), q=3, theta=24576.
REQ-034 Backpressure: stream tags 1..5 back-to-back, out_ready=0 for cycles 2-6.
  - in_ready SHALL drop once two beats are held.
  - Outputs SHALL remain stable while stalled.
  - Tags SHALL emerge 1..5 in order, once each.
REQ-035 Reset: assert rst one cycle with two beats in flight -> out_valid=0 next cycle, no in-flight beat ever appears, in_ready=1 after release.
